// File: rtl/skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer_pkg
// Description : Shared state encoding and occupancy constants for skid_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_TWO   = 2'd2;

    function automatic logic [1:0] occupancy_of(input skid_state_t s);
        case (s)
            BUSY:    return c_OCC_ONE;
            FULL:    return c_OCC_TWO;
            default: return c_OCC_EMPTY;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_data_reg.sv
`default_nettype none
// ============================================================================
// Module      : skid_data_reg
// Description : WIDTH-bit load-enable register, asynchronously cleared to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (i_en) begin
            r_data_q <= i_d;
        end
    end

    assign o_q = r_data_q;

endmodule
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry elastic stage; all handshake outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] OutData,
    input  logic             OutReady,
    output logic [1:0]       Occupancy
);
    import skid_buffer_pkg::*;

    skid_state_t      r_state_q;
    skid_state_t      w_state_d;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_in_fire  = InValid & InReady;
    assign w_out_fire = OutValid & OutReady;

    // Flush leaves both data registers untouched; only the state is cleared.
    always_comb begin
        w_state_d = r_state_q;
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        w_main_d  = InData;
        if (Flush) begin
            w_state_d = EMPTY;
        end else begin
            case (r_state_q)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_en = 1'b1;
                        w_state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_en = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_en = 1'b1;
                        w_state_d = FULL;
                    end else if (w_out_fire) begin
                        w_state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_en = 1'b1;
                        w_main_d  = w_skid_q;
                        w_state_d = BUSY;
                    end
                end
                default: begin
                    w_state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= EMPTY;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    skid_data_reg #(.WIDTH(WIDTH)) u_main_reg (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_main_en),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    skid_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_skid_en),
        .i_d  (InData),
        .o_q  (w_skid_q)
    );

    // Reset gates InReady so nothing is accepted until the buffer is out of reset.
    assign InReady   = ~reset & (r_state_q != FULL);
    assign OutValid  = (r_state_q != EMPTY);
    assign OutData   = w_main_q;
    assign Occupancy = occupancy_of(r_state_q);

endmodule
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skid_buffer
// Description : Scoreboard bench for skid_buffer with directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       Flush;
    logic       InValid;
    logic [7:0] InData;
    logic       InReady;
    logic       OutValid;
    logic [7:0] OutData;
    logic       OutReady;
    logic [1:0] Occupancy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    skid_buffer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .Flush     (Flush),
        .InValid   (InValid),
        .InData    (InData),
        .InReady   (InReady),
        .OutValid  (OutValid),
        .OutData   (OutData),
        .OutReady  (OutReady),
        .Occupancy (Occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        InValid  = iv;
        InData   = id;
        OutReady = ordy;
        Flush    = fl;
        @(posedge clk);
        #1;
    endtask

    // Inputs are stable at the falling edge, so what is seen here is what fires next.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            check("occupancy_model", {30'd0, Occupancy}, sb.size());
            check("out_valid_model", {31'd0, OutValid}, {31'd0, sb.size() != 0});
            check("in_ready_model", {31'd0, InReady}, {31'd0, sb.size() < 2});
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", {24'd0, OutData}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", {24'd0, OutData}, {24'd0, sb.pop_front()});
                end
            end
            if (Flush) begin
                sb.delete();
            end else if (InValid && InReady) begin
                sb.push_back(InData);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pre_data;
        logic       pre_ir;
        logic       pre_ov;
        logic [1:0] pre_occ;

        reset    = 1'b1;
        Flush    = 1'b0;
        InValid  = 1'b0;
        InData   = 8'h00;
        OutReady = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, OutValid}, 32'd0);
        check("rst_out_data", {24'd0, OutData}, 32'd0);
        check("rst_in_ready", {31'd0, InReady}, 32'd0);
        check("rst_occupancy", {30'd0, Occupancy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, InReady}, 32'd1);

        // Single beat: one-cycle latency, then empty again.
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        check("single_valid", {31'd0, OutValid}, 32'd1);
        check("single_data", {24'd0, OutData}, 32'hA5);
        check("single_occ", {30'd0, Occupancy}, 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("single_valid_off", {31'd0, OutValid}, 32'd0);
        check("single_occ_off", {30'd0, Occupancy}, 32'd0);

        // Streaming 0x00..0x0F at full rate.
        for (int i = 0; i < 16; i++) begin
            InValid  = 1'b1;
            InData   = 8'(i);
            OutReady = 1'b1;
            Flush    = 1'b0;
            check("stream_in_ready", {31'd0, InReady}, 32'd1);
            @(posedge clk);
            #1;
            check("stream_valid", {31'd0, OutValid}, 32'd1);
            check("stream_data", {24'd0, OutData}, i);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_drained", {31'd0, OutValid}, 32'd0);

        // Backpressure: two stalled cycles after 0x10 appears.
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        check("bp_data0", {24'd0, OutData}, 32'h10);
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        check("bp_occ_full", {30'd0, Occupancy}, 32'd2);
        check("bp_in_ready_full", {31'd0, InReady}, 32'd0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        check("bp_occ_hold", {30'd0, Occupancy}, 32'd2);
        check("bp_in_ready_hold", {31'd0, InReady}, 32'd0);
        check("bp_data_hold", {24'd0, OutData}, 32'h10);
        drive(1'b1, 8'h12, 1'b1, 1'b0);
        check("bp_occ_busy", {30'd0, Occupancy}, 32'd1);
        check("bp_in_ready_back", {31'd0, InReady}, 32'd1);
        check("bp_data1", {24'd0, OutData}, 32'h11);
        drive(1'b1, 8'h12, 1'b1, 1'b0);
        check("bp_data2", {24'd0, OutData}, 32'h12);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("bp_empty", {30'd0, Occupancy}, 32'd0);

        // Flush while FULL with a beat on offer.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        check("fl_pre_occ", {30'd0, Occupancy}, 32'd2);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        check("fl_valid", {31'd0, OutValid}, 32'd0);
        check("fl_occ", {30'd0, Occupancy}, 32'd0);
        check("fl_in_ready", {31'd0, InReady}, 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("fl_no_ghost", {31'd0, OutValid}, 32'd0);

        // Asynchronous reset between edges while FULL.
        drive(1'b1, 8'h30, 1'b0, 1'b0);
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        check("ar_pre_occ", {30'd0, Occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", {31'd0, OutValid}, 32'd0);
        check("ar_data", {24'd0, OutData}, 32'd0);
        check("ar_in_ready", {31'd0, InReady}, 32'd0);
        check("ar_occ", {30'd0, Occupancy}, 32'd0);
        @(posedge clk);
        #1;
        InValid = 1'b0;
        reset   = 1'b0;
        #1;
        drive(1'b1, 8'h40, 1'b1, 1'b0);
        check("ar_resume", {24'd0, OutData}, 32'h40);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic; outputs must not move when only the inputs move.
        for (int c = 0; c < 10000; c++) begin
            pre_ir   = InReady;
            pre_ov   = OutValid;
            pre_data = OutData;
            pre_occ  = Occupancy;
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 1));
            InData   = 8'($urandom_range(0, 255));
            Flush    = 1'b0;
            #1;
            check("rnd_no_comb_path", {19'd0, InReady, OutValid, OutData, Occupancy},
                  {19'd0, pre_ir, pre_ov, pre_data, pre_occ});
            @(posedge clk);
            #1;
        end
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("rnd_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
